// File: rtl/dma_ctrl_pkg.sv
// Shared types and default widths for the memory-to-memory copy engine.
package dma_ctrl_pkg;

   localparam int unsigned DMA_AW = 8;
   localparam int unsigned DMA_DW = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_READ   = 2'd1,
      ST_WRITE  = 2'd2,
      ST_FINISH = 2'd3
   } dma_state_t;

endpackage : dma_ctrl_pkg

// File: rtl/dma_ctrl.sv
// Byte-copy DMA sharing a single memory port with a core that always wins.
// One byte moves every two cycles (read, then write); a core request stalls
// the copy in place so it resumes without skipping or repeating a byte.
module dma_ctrl
   import dma_ctrl_pkg::*;
#(
   parameter int unsigned AW = DMA_AW,
   parameter int unsigned DW = DMA_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] src,
   input  logic [AW-1:0] dst,
   input  logic [AW-1:0] len,
   input  logic          core_req,
   input  logic          core_wr_en,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_dat_in,
   input  logic [DW-1:0] mem_dat_out,
   output logic [AW-1:0] mem_addr,
   output logic          mem_wr_en,
   output logic [DW-1:0] mem_dat_in,
   output logic          busy,
   output logic          done
);

   // One extra bit so idx+1 < len cannot overflow when len is at its maximum.
   localparam int unsigned CW = AW + 1;

   dma_state_t    state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [AW-1:0] src_q, src_d;
   logic [AW-1:0] dst_q, dst_d;
   logic [AW-1:0] len_q, len_d;
   logic [DW-1:0] hold_q, hold_d;
   logic          busy_d, done_d;

   logic [AW-1:0] dma_addr_c;
   logic          dma_wr_en_c;
   logic [DW-1:0] dma_dat_c;

   // State, copy context and registered status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         hold_q  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         hold_q  <= hold_d;
         busy    <= busy_d;
         done    <= done_d;
      end
   end

   // Next-state logic and the DMA side of the memory port.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      src_d       = src_q;
      dst_d       = dst_q;
      len_d       = len_q;
      hold_d      = hold_q;
      dma_addr_c  = '0;
      dma_wr_en_c = 1'b0;
      dma_dat_c   = '0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               src_d   = src;
               dst_d   = dst;
               len_d   = len;
               idx_d   = '0;
               state_d = (len == '0) ? ST_FINISH : ST_READ;
            end
         end
         ST_READ: begin
            dma_addr_c = src_q + idx_q;
            if (!core_req) begin
               hold_d  = mem_dat_out;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            dma_addr_c  = dst_q + idx_q;
            dma_wr_en_c = 1'b1;
            dma_dat_c   = hold_q;
            if (!core_req) begin
               idx_d   = idx_q + AW'(1);
               state_d = ((CW'(idx_q) + CW'(1)) < CW'(len_q)) ? ST_READ : ST_FINISH;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d == ST_READ) || (state_d == ST_WRITE);
      done_d = (state_d == ST_FINISH);
   end

   // Memory port mux: the core owns the port whenever it asks for it.
   always_comb begin
      mem_addr   = dma_addr_c;
      mem_wr_en  = dma_wr_en_c;
      mem_dat_in = dma_dat_c;
      if (core_req) begin
         mem_addr   = core_addr;
         mem_wr_en  = core_wr_en;
         mem_dat_in = core_dat_in;
      end
   end

endmodule : dma_ctrl

// File: tb/tb_dma_ctrl.sv
// Self-checking bench for dma_ctrl: a byte memory around the DUT, a
// transaction-queue reference model, a per-cycle port compare and directed
// plus randomized scenarios.
module tb_dma_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic [7:0] src = '0, dst = '0, len = '0;
   logic       core_req = 1'b0, core_wr_en = 1'b0;
   logic [7:0] core_addr = '0, core_dat_in = '0;
   logic [7:0] mem_dat_out, mem_addr, mem_dat_in;
   logic       mem_wr_en, busy, done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   dma_ctrl #(.AW(8), .DW(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .src(src), .dst(dst), .len(len),
      .core_req(core_req), .core_wr_en(core_wr_en), .core_addr(core_addr),
      .core_dat_in(core_dat_in), .mem_dat_out(mem_dat_out), .mem_addr(mem_addr),
      .mem_wr_en(mem_wr_en), .mem_dat_in(mem_dat_in), .busy(busy), .done(done)
   );

   // Data memory attached to the DUT port
   logic [7:0] env_mem [256];
   logic       mem_clr = 1'b0;

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) env_mem[i] <= 8'h00;
      end else if (mem_wr_en) begin
         env_mem[mem_addr] <= mem_dat_in;
      end
   end
   assign mem_dat_out = env_mem[mem_addr];

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: a copy is a queue of pending memory operations
   localparam logic [1:0] K_RD = 2'd0, K_WR = 2'd1, K_FIN = 2'd2;
   typedef struct packed {
      logic [1:0] kind;
      logic [7:0] addr;
   } op_t;

   op_t        opq[$];
   logic [7:0] ref_mem [256];
   logic [7:0] rd_val = '0;

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            opq.delete();
            rd_val = '0;
         end else begin
            if (mem_clr) begin
               for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
            end else if (core_req && core_wr_en) begin
               ref_mem[core_addr] = core_dat_in;
            end
            if (opq.size() > 0) begin
               if (opq[0].kind == K_FIN) begin
                  void'(opq.pop_front());
               end else if (!core_req) begin
                  if (opq[0].kind == K_RD) rd_val = ref_mem[opq[0].addr];
                  else                     ref_mem[opq[0].addr] = rd_val;
                  void'(opq.pop_front());
               end
            end else if (start) begin
               for (int i = 0; i < int'(len); i++) begin
                  opq.push_back('{kind: K_RD, addr: 8'(src + 8'(i))});
                  opq.push_back('{kind: K_WR, addr: 8'(dst + 8'(i))});
               end
               opq.push_back('{kind: K_FIN, addr: 8'h00});
            end
         end
      end
   end

   // Per-cycle compare of the port and status outputs against the model
   logic done_seen = 1'b0;
   int   done_cyc = 0, done_cnt = 0, busy_cnt = 0, dma_wr_cnt = 0, first_wr_cyc = -1;
   logic [7:0] ea, ed;
   logic       ew, eb, edn, cd;

   always @(negedge clk) begin
      if (rst_n) begin
         eb  = (opq.size() > 0) && (opq[0].kind != K_FIN);
         edn = (opq.size() > 0) && (opq[0].kind == K_FIN);
         cd  = 1'b1;
         if (core_req) begin
            ea = core_addr; ew = core_wr_en; ed = core_dat_in;
         end else if (!eb) begin
            ea = 8'h00; ew = 1'b0; ed = 8'h00;
         end else if (opq[0].kind == K_RD) begin
            ea = opq[0].addr; ew = 1'b0; ed = 8'h00; cd = 1'b0;
         end else begin
            ea = opq[0].addr; ew = 1'b1; ed = rd_val;
         end
         checks++;
         if (mem_addr !== ea || mem_wr_en !== ew || (cd && mem_dat_in !== ed) ||
             busy !== eb || done !== edn) begin
            errors++;
            $display("FAIL port cycle %0d: got addr=%h wr=%b dat=%h busy=%b done=%b, expected addr=%h wr=%b dat=%h busy=%b done=%b",
                     cyc, mem_addr, mem_wr_en, mem_dat_in, busy, done, ea, ew, ed, eb, edn);
         end
         if (done) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
            done_cnt++;
         end
         if (busy) busy_cnt++;
         if (mem_wr_en && !core_req) begin
            dma_wr_cnt++;
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
         end
      end
   end

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      start = 1'b0; core_req = 1'b0; core_wr_en = 1'b0;
      core_addr = '0; core_dat_in = '0;
   endtask

   task automatic core_write(input logic [7:0] a, input logic [7:0] d);
      core_req = 1'b1; core_wr_en = 1'b1; core_addr = a; core_dat_in = d;
      tick();
      drive_idle();
   endtask

   task automatic start_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                             output int c);
      done_seen = 1'b0; busy_cnt = 0; dma_wr_cnt = 0; first_wr_cyc = -1; done_cnt = 0;
      start = 1'b1; src = s; dst = d; len = l;
      c = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done_seen && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (!done_seen) begin
         errors++;
         $display("FAIL %s_timeout: got no done within 100 cycles, expected a done pulse", name);
      end
      tick();
   endtask

   logic [7:0] t1_exp [4];
   logic [7:0] vals [8];

   initial begin
      int c;
      int bad;
      t1_exp[0] = 8'hA1; t1_exp[1] = 8'hB2; t1_exp[2] = 8'hC3; t1_exp[3] = 8'hD4;

      // Reset state
      #1 rst_n = 1'b0;
      #2;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_wr_en", int'(mem_wr_en), 0);
      chk("rst_addr", int'(mem_addr), 0);
      repeat (2) tick();
      rst_n = 1'b1;
      mem_clr = 1'b1;
      tick();
      mem_clr = 1'b0;

      // Basic 4-byte copy with exact timing
      for (int i = 0; i < 4; i++) core_write(8'(8'h10 + 8'(i)), t1_exp[i]);
      start_copy(8'h10, 8'h40, 8'd4, c);
      wait_done("basic");
      chk("basic_done_cycle", done_cyc - c, 9);
      chk("basic_busy_cycles", busy_cnt, 8);
      chk("basic_dma_writes", dma_wr_cnt, 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("basic_dst_%0d", i), int'(env_mem[8'h40 + i]), int'(t1_exp[i]));
         chk($sformatf("basic_model_%0d", i), int'(ref_mem[8'h40 + i]), int'(t1_exp[i]));
      end

      // Address wrap on the source side
      core_write(8'hFE, 8'h11); core_write(8'hFF, 8'h22);
      core_write(8'h00, 8'h33); core_write(8'h01, 8'h44);
      start_copy(8'hFE, 8'h02, 8'd4, c);
      wait_done("wrap");
      chk("wrap_dst_2", int'(env_mem[2]), 'h11);
      chk("wrap_dst_3", int'(env_mem[3]), 'h22);
      chk("wrap_dst_4", int'(env_mem[4]), 'h33);
      chk("wrap_dst_5", int'(env_mem[5]), 'h44);

      // Core write steals the port for 3 cycles during the first WRITE
      core_write(8'h20, 8'h5A); core_write(8'h21, 8'h6B);
      core_write(8'h22, 8'h7C); core_write(8'h23, 8'h8D);
      start_copy(8'h20, 8'h60, 8'd4, c);
      tick();
      core_req = 1'b1; core_wr_en = 1'b1; core_addr = 8'h80; core_dat_in = 8'hEE;
      repeat (3) tick();
      drive_idle();
      wait_done("stall");
      chk("stall_done_cycle", done_cyc - c, 12);
      chk("stall_first_dma_wr", first_wr_cyc - c, 5);
      chk("stall_core_wr", int'(env_mem[8'h80]), 'hEE);
      chk("stall_dst_0", int'(env_mem[8'h60]), 'h5A);
      chk("stall_dst_3", int'(env_mem[8'h63]), 'h8D);

      // Zero-length copy
      start_copy(8'h30, 8'h31, 8'd0, c);
      wait_done("len0");
      chk("len0_done_cycle", done_cyc - c, 1);
      chk("len0_dma_writes", dma_wr_cnt, 0);

      // Start while busy is ignored
      for (int i = 0; i < 6; i++) begin
         vals[i] = 8'($urandom_range(1, 255));
         core_write(8'(8'h50 + 8'(i)), vals[i]);
      end
      start_copy(8'h50, 8'h70, 8'd6, c);
      repeat (3) tick();
      start = 1'b1; src = 8'h00; dst = 8'h90; len = 8'd5;
      tick();
      start = 1'b0;
      wait_done("busy_start");
      chk("busy_start_done_cycle", done_cyc - c, 13);
      chk("busy_start_done_cnt", done_cnt, 1);
      for (int i = 0; i < 6; i++)
         chk($sformatf("busy_start_dst_%0d", i), int'(env_mem[8'h70 + i]), int'(vals[i]));
      chk("busy_start_no_2nd", int'(env_mem[8'h90]), 0);

      // Reset after the second byte of an 8-byte copy
      for (int i = 0; i < 8; i++) begin
         core_write(8'(8'hA0 + 8'(i)), 8'(i + 1));
         core_write(8'(8'hC0 + 8'(i)), 8'hFF);
      end
      start_copy(8'hA0, 8'hC0, 8'd8, c);
      repeat (4) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_wr_en", int'(mem_wr_en), 0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (20) tick();
      chk("abort_done_cnt", done_cnt, 0);
      for (int i = 0; i < 8; i++)
         chk($sformatf("abort_dst_%0d", i), int'(env_mem[8'hC0 + i]), (i < 2) ? i + 1 : 'hFF);

      // Randomized traffic: overlapping copies, core contention, stray starts
      for (int n = 0; n < 3000; n++) begin
         start       = ($urandom_range(0, 7) == 0);
         src         = 8'($urandom);
         dst         = 8'($urandom);
         len         = 8'($urandom_range(0, 12));
         core_req    = ($urandom_range(0, 3) == 0);
         core_wr_en  = 1'($urandom);
         core_addr   = 8'($urandom);
         core_dat_in = 8'($urandom);
         tick();
      end
      drive_idle();
      repeat (40) tick();
      chk("rand_idle_queue", opq.size(), 0);

      // Whole-memory image against the model
      bad = 0;
      for (int i = 0; i < 256; i++) if (env_mem[i] !== ref_mem[i]) bad++;
      chk("final_mem_image_diffs", bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_dma_ctrl

// File: doc/dma_ctrl.md
DMA_CTRL -- requirements
Module: dma_ctrl

Interface
REQ-001 Parameter AW, default 8: address width; memory depth is 2**AW bytes.
REQ-002 Parameter DW, default 8: data width.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to begin a copy; sampled only in IDLE.
REQ-006 src  input  AW  source base address; captured when start is accepted.
REQ-007 dst  input  AW  destination base address; captured when start is accepted.
REQ-008 len  input  AW  byte count; captured when start is accepted; 0 means no transfer.
REQ-009 core_req  input  1  core claims the memory port this cycle.
REQ-010 core_wr_en  input  1  core write enable; valid when core_req=1.
REQ-011 core_addr  input  AW  core address.
REQ-012 core_dat_in  input  DW  core write data.
REQ-013 mem_dat_out  input  DW  combinational read data from the data memory.
REQ-014 mem_addr  output  AW  address to the data memory.
REQ-015 mem_wr_en  output  1  write enable to the data memory.
REQ-016 mem_dat_in  output  DW  write data to the data memory.
REQ-017 busy  output  1  high from the cycle after start acceptance until done.
REQ-018 done  output  1  one-cycle pulse on copy completion.

Function
REQ-019 States: IDLE, READ, WRITE, FINISH; IDLE->READ on start with len!=0; IDLE->FINISH on start with len==0.
REQ-020 READ: drive mem_addr=src+idx and mem_wr_en=0; at the clock edge latch mem_dat_out into a DW-bit holding register; go to WRITE.
REQ-021 WRITE: drive mem_addr=dst+idx, mem_wr_en=1, mem_dat_in=holding register; then increment idx; go to READ if idx+1<len, else FINISH.
REQ-022 FINISH: assert done for exactly one cycle; return to IDLE; busy=0 during FINISH.
REQ-023 Address arithmetic is modulo 2**AW; src+idx and dst+idx wrap from 2**AW-1 to 0.
REQ-024 Copy order is strictly ascending idx; overlapping regions produce the result of that order, with no special handling.
REQ-025 Core priority: while core_req=1, mem_addr/mem_wr_en/mem_dat_in pass core_addr/core_wr_en/core_dat_in and the FSM, idx and holding register hold their values.
REQ-026 A stalled READ or WRITE resumes unchanged in the first cycle with core_req=0; no byte is skipped or duplicated.
REQ-027 In IDLE and FINISH with core_req=0: mem_wr_en=0, mem_addr=0, mem_dat_in=0.
REQ-028 start outside IDLE is ignored; start and core_req in the same IDLE cycle both take effect.
REQ-029 Throughput is 2 cycles per byte without contention; an N-byte copy with no stalls asserts done 2N+1 cycles after the start cycle.

Reset
REQ-030 rst_n low immediately forces IDLE, idx=0, holding register=0, busy=0, done=0, and mem_wr_en=0 unless core_req=1.
REQ-031 Reset asserted mid-copy aborts the copy with no further DMA write; done is not pulsed.

Structure
REQ-032 A shared package holds the state enum (dma_state_t) and the AW/DW defaults.
REQ-033 No sub-module is required; the port mux is a combinational block inside dma_ctrl.

Verification
REQ-034 Preload mem[0x10..0x13]=A1,B2,C3,D4; start src=0x10 dst=0x40 len=4 -> mem[0x40..0x43]=A1,B2,C3,D4; done 9 cycles after start; busy high for cycles 1-8.
REQ-035 src=0xFE dst=0x02 len=4 -> bytes from 0xFE,0xFF,0x00,0x01 written to 0x02-0x05 in that order.
REQ-036 core_req=1 with core_wr_en=1 for 3 cycles during WRITE -> core write lands; DMA write is delayed 3 cycles; final copy is correct; done is delayed 3 cycles.
REQ-037 len=0 -> no mem_wr_en from the DMA; done pulses in the cycle after start.
REQ-038 rst_n low after the 2nd byte of an 8-byte copy -> only 2 destination bytes change; busy=0 and done=0 immediately.
REQ-039 start pulsed while busy -> ignored; the original copy completes unchanged.
